clk_monitor: RTL
================

// Module: clk_monitor
// PURPOSE
//   System-domain observer for a divided clock, such as the output of clk_div
//   driving the 6502 core. It samples clk_in on clk and emits one-cycle rise and
//   fall strobes. It measures every half-period and compares it against the
//   nominal value. It reports lock, clock-stopped and period-fault status.
// PARAMETERS
//   SYS_CLK    12000000  system clock frequency, Hz
//   CLK_IN     1000000   expected clk_in frequency, Hz
//   HALF_NOM   SYS_CLK/(2*CLK_IN)  nominal half-period in clk cycles (6 by default)
//   TOL        1         allowed deviation in cycles, |meas-HALF_NOM| <= TOL
//   LOCK_COUNT 4         consecutive in-range halves needed to reach lock
//   CNT_W      16        width of the half-period counter
// PORTS
//   clk        in   1      system clock; all logic on posedge
//   rst        in   1      asynchronous, active-high reset
//   enable     in   1      monitor enable
//   clk_in     in   1      monitored clock, asynchronous to clk
//   rise       out  1      one-cycle strobe on a synchronised rising edge
//   fall       out  1      one-cycle strobe on a synchronised falling edge
//   locked     out  1      high while in LOCKED
//   stopped    out  1      high while in STOPPED
//   fault      out  1      one-cycle pulse: lock lost
//   fault_cnt  out  8      saturating count of fault pulses
// BEHAVIOUR
//   Synchroniser: clk_in -> s1 -> s2 -> s3.
//     - rise = s2 & ~s3; fall = ~s2 & s3; edge = rise | fall.
//     - clk_in changing just after clk edge k gives a strobe in the cycle after edge k+2.
//   half_cnt:
//     - cleared to 0 on edge; otherwise increments, saturating at all-ones.
//     - meas = half_cnt + 1 on edge, i.e. clk cycles between consecutive strobes.
//     - in_range = |meas - HALF_NOM| <= TOL; compute with CNT_W+1 signed arithmetic.
//   timeout = !edge && half_cnt >= HALF_NOM+TOL. Edge wins over timeout when both coincide.
//   good_cnt: counter of 0..LOCK_COUNT.
//   FSM states STOPPED, UNLOCKED, LOCKED. Reset state is STOPPED.
//     - STOPPED: edge -> UNLOCKED with good_cnt=0. That edge's period is discarded.
//     - UNLOCKED, in-range edge: good_cnt++; good_cnt reaching LOCK_COUNT -> LOCKED.
//     - UNLOCKED, out-of-range edge: good_cnt=0.
//     - LOCKED, in-range edge: stay in LOCKED.
//     - LOCKED, out-of-range edge: -> UNLOCKED, good_cnt=0, fault pulse.
//     - Any state, timeout -> STOPPED. Fault pulses only if leaving LOCKED.
//   Outputs are registered, so locked/stopped/fault change the cycle after the deciding edge strobe.
//   fault_cnt increments with each fault pulse and holds at 255.
//   enable=0:
//     - forces STOPPED; half_cnt and good_cnt held at 0.
//     - no fault pulses.
//     - rise/fall strobes still generated.
//   Reset values:
//     - s1..s3, half_cnt, good_cnt, fault_cnt = 0.
//     - rise=fall=locked=fault=0; stopped=1.
//   Asynchronous reset mid-lock returns to these values immediately.
// CONFIGURATION
//   CLK_MON_PERIOD_EN defined:
//     - adds output period [CNT_W-1:0]: last meas value, updated on every edge while enable=1.
//     - adds output period_vld [1]: one-cycle pulse with each update.
//     - both reset to 0.
//   CLK_MON_PERIOD_EN undefined: both ports and their logic are absent; all else identical.
// TESTING
//   Defaults used throughout: HALF_NOM=6, TOL=1, LOCK_COUNT=4.
//   Reset, no clk_in activity -> stopped=1, locked=0, fault=0, fault_cnt=0.
//   clk_in toggles every 6 clk, enable=1 -> first strobe moves STOPPED->UNLOCKED;
//     locked=1 the cycle after the 5th strobe; no fault pulses.
//   Locked, then halves of 5 and 7 cycles -> locked stays 1.
//   Locked, then one half of 3 cycles -> fault pulses once; locked=0; fault_cnt=1.
//     Four more 6-cycle halves relock.
//   Locked, clk_in held -> stopped=1 and locked=0 one cycle after half_cnt reaches 7;
//     fault=1 once. Resuming toggles relock after 5 strobes.
//   Locked, rst pulsed mid-half -> all outputs back to reset values asynchronously.
//   With CLK_MON_PERIOD_EN: period=6 with period_vld on every strobe.

Source files
------------

// File: rtl/clk_monitor.sv
// Divided-clock observer: synchronises clk_in, strobes its edges, times each half-period
// and tracks STOPPED/UNLOCKED/LOCKED. Define CLK_MON_PERIOD_EN to add period/period_vld outputs.
`timescale 1ns/1ps

module clk_monitor #(
  parameter int SYS_CLK    = 12000000,
  parameter int CLK_IN     = 1000000,
  parameter int HALF_NOM   = SYS_CLK / (2 * CLK_IN),
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clk_in,
  output logic             rise,
  output logic             fall,
  output logic             locked,
  output logic             stopped,
  output logic             fault,
  output logic [7:0]       fault_cnt
`ifdef CLK_MON_PERIOD_EN
  ,
  output logic [CNT_W-1:0] period,
  output logic             period_vld
`endif
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic signed [CNT_W:0] HALF_S  = (CNT_W+1)'(HALF_NOM);
  localparam logic signed [CNT_W:0] TOL_S   = (CNT_W+1)'(TOL);
  localparam logic [CNT_W-1:0]      TMO_LIM = CNT_W'(HALF_NOM + TOL);
  localparam logic [GOOD_W-1:0]     LOCK_G  = GOOD_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_UNLOCKED,
    ST_LOCKED
  } state_t;

  state_t              state, state_next;
  logic                s1, s2, s3;
  logic                clk_edge;
  logic [CNT_W-1:0]    half_cnt, half_next;
  logic [CNT_W-1:0]    meas;
  logic signed [CNT_W:0] diff;
  logic                in_range;
  logic                timeout;
  logic [GOOD_W-1:0]   good_cnt, good_next, good_inc;
  logic                fault_next;

  // s1 is the metastability stage; s2/s3 form the edge detector.
  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign clk_edge = s2 ^ s3;

  assign meas     = half_cnt + CNT_W'(1);
  assign diff     = $signed({1'b0, meas}) - HALF_S;
  assign in_range = (diff <= TOL_S) && (diff >= -TOL_S);
  assign timeout  = !clk_edge && (half_cnt >= TMO_LIM);
  assign good_inc = good_cnt + GOOD_W'(1);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    fault_next = 1'b0;
    half_next  = half_cnt;

    if (!enable) begin
      half_next  = '0;
      good_next  = '0;
      state_next = ST_STOPPED;
    end else begin
      if (clk_edge)            half_next = '0;
      else if (half_cnt != '1) half_next = half_cnt + CNT_W'(1);

      // An edge takes priority over a coincident timeout.
      if (clk_edge) begin
        case (state)
          ST_STOPPED: begin
            state_next = ST_UNLOCKED;
            good_next  = '0;
          end
          ST_UNLOCKED: begin
            if (in_range) begin
              good_next = good_inc;
              if (good_inc == LOCK_G) state_next = ST_LOCKED;
            end else begin
              good_next = '0;
            end
          end
          ST_LOCKED: begin
            if (!in_range) begin
              state_next = ST_UNLOCKED;
              good_next  = '0;
              fault_next = 1'b1;
            end
          end
          default: begin
            state_next = ST_STOPPED;
            good_next  = '0;
          end
        endcase
      end else if (timeout) begin
        state_next = ST_STOPPED;
        good_next  = '0;
        fault_next = (state == ST_LOCKED);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_STOPPED;
      half_cnt  <= '0;
      good_cnt  <= '0;
      fault     <= 1'b0;
      fault_cnt <= '0;
    end else begin
      state    <= state_next;
      half_cnt <= half_next;
      good_cnt <= good_next;
      fault    <= fault_next;
      if (fault_next && fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
    end
  end

  assign locked  = (state == ST_LOCKED);
  assign stopped = (state == ST_STOPPED);

`ifdef CLK_MON_PERIOD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period     <= '0;
      period_vld <= 1'b0;
    end else begin
      period_vld <= enable & clk_edge;
      if (enable && clk_edge) period <= meas;
    end
  end
`endif

endmodule
